// File: rtl/ucsbece154b_icache_pkg.sv
// Shared constants for the instruction cache: FSM state encodings and default geometry.
package ucsbece154b_icache_pkg;

  localparam int unsigned DefNumSets    = 8;
  localparam int unsigned DefBlockWords = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// One way of the instruction cache: data, tag and valid arrays, single write port,
// combinational read and hit detection.
module ucsbece154b_icache_way
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NumSets    = DefNumSets,
  parameter int unsigned BlockWords = DefBlockWords,
  parameter int unsigned SetW       = $clog2(NumSets),
  parameter int unsigned WordW      = $clog2(BlockWords),
  parameter int unsigned TagBits    = 32 - SetW - WordW - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SetW-1:0]    rd_set_i,
  input  logic [WordW-1:0]   rd_word_i,
  input  logic [TagBits-1:0] rd_tag_i,
  output logic               valid_o,
  output logic               hit_o,
  output logic [31:0]        rdata_o,
  input  logic               wr_en_i,
  input  logic [SetW-1:0]    wr_set_i,
  input  logic [WordW-1:0]   wr_word_i,
  input  logic [31:0]        wr_data_i,
  input  logic               tag_wr_i,
  input  logic [TagBits-1:0] wr_tag_i
);

  logic [31:0]        data_q [NumSets][BlockWords];
  logic [TagBits-1:0] tag_q  [NumSets];
  logic [NumSets-1:0] valid_q;

  // Data and tags carry no reset; only the valid bits decide what is usable.
  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[wr_set_i][wr_word_i] <= wr_data_i;
    if (tag_wr_i) tag_q[wr_set_i] <= wr_tag_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (tag_wr_i) begin
      valid_q[wr_set_i] <= 1'b1;
    end
  end

  assign valid_o = valid_q[rd_set_i];
  assign hit_o   = valid_o && (tag_q[rd_set_i] == rd_tag_i);
  assign rdata_o = data_q[rd_set_i][rd_word_i];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Two-way set-associative instruction cache with LRU replacement and a beat-wise
// block refill FSM (IDLE -> REQ -> FILL -> DONE).
module ucsbece154b_icache
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = DefNumSets,
  parameter int unsigned BLOCK_WORDS = DefBlockWords
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadEnable_i,
  input  logic [31:0] PCF_i,
  output logic [31:0] Instruction_o,
  output logic        Ready_o,
  output logic        MemReadRequest_o,
  output logic [31:0] MemReadAddress_o,
  input  logic        MemDataReady_i,
  input  logic [31:0] MemDataIn_i
);

  localparam int unsigned WordW   = $clog2(BLOCK_WORDS);
  localparam int unsigned SetW    = $clog2(NUM_SETS);
  localparam int unsigned OffW    = WordW + 2;
  localparam int unsigned TagBits = 32 - SetW - OffW;

  state_e              state_q, state_d;
  logic [31:0]         miss_addr_q, miss_addr_d;
  logic [WordW-1:0]    cnt_q, cnt_d;
  logic                victim_q, victim_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic [SetW-1:0]    pc_set, miss_set;
  logic [WordW-1:0]   pc_word;
  logic [TagBits-1:0] pc_tag, miss_tag;
  logic [1:0]         hit, valid, wr_en;
  logic [31:0]        rdata [2];
  logic               fill_we, fill_last;

  assign pc_set   = PCF_i[OffW +: SetW];
  assign pc_word  = PCF_i[2 +: WordW];
  assign pc_tag   = PCF_i[31 -: TagBits];
  assign miss_set = miss_addr_q[OffW +: SetW];
  assign miss_tag = miss_addr_q[31 -: TagBits];

  // Refill writes are suppressed while reset is high so an abandoned fill leaves no trace.
  assign wr_en[0] = fill_we && !reset && !victim_q;
  assign wr_en[1] = fill_we && !reset && victim_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    ucsbece154b_icache_way #(
      .NumSets   (NUM_SETS),
      .BlockWords(BLOCK_WORDS)
    ) u_way (
      .clk      (clk),
      .reset    (reset),
      .rd_set_i (pc_set),
      .rd_word_i(pc_word),
      .rd_tag_i (pc_tag),
      .valid_o  (valid[w]),
      .hit_o    (hit[w]),
      .rdata_o  (rdata[w]),
      .wr_en_i  (wr_en[w]),
      .wr_set_i (miss_set),
      .wr_word_i(cnt_q),
      .wr_data_i(MemDataIn_i),
      .tag_wr_i (wr_en[w] && fill_last),
      .wr_tag_i (miss_tag)
    );
  end

  assign Instruction_o    = hit[0] ? rdata[0] : (hit[1] ? rdata[1] : 32'h0);
  assign MemReadAddress_o = {miss_addr_q[31:OffW], {OffW{1'b0}}};

  always_comb begin
    state_d          = state_q;
    miss_addr_d      = miss_addr_q;
    cnt_d            = cnt_q;
    victim_d         = victim_q;
    lru_d            = lru_q;
    Ready_o          = 1'b0;
    MemReadRequest_o = 1'b0;
    fill_we          = 1'b0;
    fill_last        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ReadEnable_i) begin
          Ready_o = 1'b1;
        end else if (|hit) begin
          Ready_o       = 1'b1;
          lru_d[pc_set] = !hit[1];
        end else begin
          miss_addr_d = PCF_i;
          // Prefer an empty way; otherwise evict the way the LRU bit points at.
          victim_d    = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru_q[pc_set]);
          state_d     = StReq;
        end
      end
      StReq: begin
        MemReadRequest_o = 1'b1;
        cnt_d            = '0;
        state_d          = StFill;
      end
      StFill: begin
        if (MemDataReady_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + WordW'(1);
          if (cnt_q == WordW'(BLOCK_WORDS - 1)) begin
            fill_last       = 1'b1;
            lru_d[miss_set] = !victim_q;
            state_d         = StDone;
          end
        end
      end
      StDone: begin
        Ready_o = ReadEnable_i && (PCF_i == miss_addr_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      cnt_q       <= cnt_d;
      victim_q    <= victim_d;
      lru_q       <= lru_d;
    end
  end

endmodule
